bank_accounter: RTL

Tracks, for every memory address, which write-agent bank holds the most recent data. Presents the per-read-agent bank selector consumed by the read switch in the same cycle as the read request. Sits beside the BRAM banks, upstream of the read switch: write agents update it, read agents query it. Also flags same-address write collisions and counts them in a saturating counter.

---
 rtl/bank_accounter.sv | 99 +++++++++
 1 files changed

// File: rtl/bank_accounter.sv
// bank_accounter: per-address record of which write bank holds the newest data.
// Write agents update the record one cycle after their write; read agents get a
// combinational bank selector (read-first against same-cycle writes). Cycles in
// which any address sees two or more writers are counted in a saturating counter.
module bank_accounter #(
  parameter int ADDR_WIDTH      = 3,
  parameter int NB_WRAGENT      = 2,
  parameter int NB_RDAGENT      = 2,
  parameter int WRITE_COLLISION = 1,
  parameter int SELECT_WIDTH    = (NB_WRAGENT == 1 ? 1 : $clog2(NB_WRAGENT)) + WRITE_COLLISION,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [NB_WRAGENT-1:0]              wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   wraddr,
  input  logic [NB_RDAGENT-1:0]              rden,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   rdaddr,
  output logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select,
  input  logic                               cnt_clear,
  output logic [CNT_WIDTH-1:0]               wrcollision_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int IDX_W = SELECT_WIDTH - WRITE_COLLISION;

  logic [SELECT_WIDTH-1:0] entry_q  [DEPTH];
  logic [SELECT_WIDTH-1:0] wr_entry [DEPTH];
  logic [IDX_W-1:0]        wr_idx   [DEPTH];
  logic [DEPTH-1:0]        wr_hit;
  logic [DEPTH-1:0]        wr_multi;
  logic                    any_collision;

  // Resolve every address independently: who writes it, and is there more than one writer.
  // Agents are scanned in ascending order so the highest writing agent wins the index.
  always_comb begin
    wr_hit   = '0;
    wr_multi = '0;
    for (int a = 0; a < DEPTH; a++) begin
      wr_idx[a] = '0;
      for (int i = 0; i < NB_WRAGENT; i++) begin
        if (wren[i] && (wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(a))) begin
          if (wr_hit[a]) wr_multi[a] = 1'b1;
          wr_hit[a] = 1'b1;
          if (NB_WRAGENT > 1) wr_idx[a] = IDX_W'(i);
        end
      end
    end
  end

  assign any_collision = |wr_multi;

  // Assemble the new entry; the flag bit only exists when collisions are stored.
  generate
    if (WRITE_COLLISION == 1) begin : g_flag
      // Entry = {collision flag, bank index}.
      always_comb begin
        for (int a = 0; a < DEPTH; a++) wr_entry[a] = {wr_multi[a], wr_idx[a]};
      end
    end else begin : g_noflag
      // Entry = bank index only.
      always_comb begin
        for (int a = 0; a < DEPTH; a++) wr_entry[a] = wr_idx[a];
      end
    end
  endgenerate

  // Table of flops; only addresses written this cycle change.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int a = 0; a < DEPTH; a++) entry_q[a] <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (wr_hit[a]) entry_q[a] <= wr_entry[a];
      end
    end
  end

  // Combinational lookup; reads see the pre-write contents (read-first).
  always_comb begin
    bank_select = '0;
    for (int r = 0; r < NB_RDAGENT; r++) begin
      if (rden[r])
        bank_select[r*SELECT_WIDTH +: SELECT_WIDTH] = entry_q[rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  // Saturating collision-cycle counter; a clear overrides a same-cycle event.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wrcollision_cnt <= '0;
    end else if (cnt_clear) begin
      wrcollision_cnt <= '0;
    end else if (any_collision && (wrcollision_cnt != '1)) begin
      wrcollision_cnt <= wrcollision_cnt + 1'b1;
    end
  end

endmodule
